// File: rtl/fpdiv_frontend.sv
// Request/response front end for the iterative fpdiv core: resolves IEEE-754
// special cases locally and sequences one core operation per normal request.
module fpdiv_frontend #(
    parameter int CORE_CYCLES = 12,
    parameter int CNT_W       = $clog2(CORE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_dividend,
    input  logic [31:0] in_divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [1:0]  out_flags,
    output logic        core_start,
    output logic [31:0] core_dividend,
    output logic [31:0] core_divisor,
    input  logic [31:0] core_quotient
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

    typedef struct packed {
        logic sign;
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } fp_class_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] result;
        logic [1:0]  flags;   // {NV, DZ}
    } special_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    fp_class_t         cls_n, cls_d;
    special_t          spec;
    logic              accept;
    logic              sign_q;

    // Zero exponent counts as zero, which flushes subnormals to signed zero.
    function automatic fp_class_t classify(input logic [31:0] x);
        fp_class_t  c;
        logic [7:0] e;
        logic [22:0] m;
        e      = x[30:23];
        m      = x[22:0];
        c.sign = x[31];
        c.zero = (e == 8'h00);
        c.inf  = (e == 8'hFF) && (m == 23'd0);
        c.nan  = (e == 8'hFF) && (m != 23'd0);
        c.snan = c.nan && !m[22];
        return c;
    endfunction

    assign cls_n    = classify(in_dividend);
    assign cls_d    = classify(in_divisor);
    assign sign_q   = cls_n.sign ^ cls_d.sign;
    assign in_ready = !reset && (state == IDLE);
    assign accept   = in_valid && in_ready;

    // Priority order matters: NaNs first, then invalid forms, then div-by-zero.
    always_comb begin
        spec = '0;
        if (cls_n.snan || cls_d.snan) begin
            spec.hit    = 1'b1;
            spec.result = QNAN;
            spec.flags  = 2'b10;
        end else if (cls_n.nan || cls_d.nan) begin
            spec.hit    = 1'b1;
            spec.result = QNAN;
        end else if ((cls_n.zero && cls_d.zero) || (cls_n.inf && cls_d.inf)) begin
            spec.hit    = 1'b1;
            spec.result = QNAN;
            spec.flags  = 2'b10;
        end else if (cls_d.zero && !cls_n.inf) begin
            spec.hit    = 1'b1;
            spec.result = {sign_q, 8'hFF, 23'd0};
            spec.flags  = 2'b01;
        end else if (cls_n.inf) begin
            spec.hit    = 1'b1;
            spec.result = {sign_q, 8'hFF, 23'd0};
        end else if (cls_d.inf || cls_n.zero) begin
            spec.hit    = 1'b1;
            spec.result = {sign_q, 31'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = spec.hit ? DONE : LAUNCH;
            LAUNCH:  state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are written only on accept, so they stay put through the capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_flags     <= '0;
            core_start    <= 1'b0;
            core_dividend <= '0;
            core_divisor  <= '0;
            cnt           <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (spec.hit) begin
                            out_result <= spec.result;
                            out_flags  <= spec.flags;
                            out_valid  <= 1'b1;
                        end else begin
                            core_dividend <= in_dividend;
                            core_divisor  <= in_divisor;
                            core_start    <= 1'b1;
                        end
                    end
                end
                LAUNCH: cnt <= CNT_W'(CORE_CYCLES - 1);
                BUSY: begin
                    if (cnt == '0) begin
                        out_result <= core_quotient;
                        out_flags  <= 2'b00;
                        out_valid  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fpdiv_frontend.md
Name: fpdiv_frontend

Overview:
Request/response front end for the iterative single-precision divider core (fpdiv).
- Accepts operand pairs over a valid/ready handshake.
- Resolves IEEE-754 special cases without using the core.
- For normal operands, sequences one core operation and holds the operands stable for the full iteration count.
- Returns the quotient plus exception flags over a valid/ready handshake.
- Sits between any initiator (bench driver, test-vector player, future FPU issue logic) and fpdiv. Completion timing comes from this block's counter, not from core internals.

Parameters:
CORE_CYCLES, 12, cycles from core_start to a valid core_quotient (6 iterations x 2 stages).
CNT_W, $clog2(CORE_CYCLES+1), busy counter width.

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  request valid.
in_ready  out  1  block can accept a request.
in_dividend  in  32  IEEE single N.
in_divisor  in  32  IEEE single D.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_result  out  32  IEEE single quotient.
out_flags  out  2  {NV invalid, DZ divide-by-zero}.
core_start  out  1  one-cycle pulse; core restarts its iteration sequence.
core_dividend  out  32  registered operand to core.
core_divisor  out  32  registered operand to core.
core_quotient  in  32  core result; valid CORE_CYCLES cycles after the core_start cycle.

Behaviour:
- Reset (synchronous, while reset=1 at the clock edge): state=IDLE; outputs/registers cleared:
  - out_valid=0, out_result=0, out_flags=0
  - core_start=0, core_dividend=0, core_divisor=0
  - counter=0
- in_ready is 0 while reset is high and equals (state==IDLE) otherwise.
- States: IDLE, LAUNCH, BUSY, DONE.
- IDLE: on in_valid&in_ready at edge T, classify the operands. Subnormal inputs are flushed to signed zero before classification.
  - Special case: load out_result/out_flags, go to DONE. out_valid=1 from T+1.
  - Normal case: latch operands into core_dividend/core_divisor, go to LAUNCH.
- LAUNCH: core_start=1 for exactly this cycle (T+1); counter=CORE_CYCLES-1; go to BUSY.
- BUSY: counter decrements each cycle. At counter==0, capture core_quotient into out_result (out_flags=00) and go to DONE.
  - out_valid=1 from T+2+CORE_CYCLES.
  - core_dividend/core_divisor stay constant from LAUNCH through the capture cycle.
- DONE: out_valid=1. out_result/out_flags are held stable while out_ready=0. On out_ready=1, go to IDLE next cycle. in_ready=0 during DONE, so there is no same-cycle overlap.
- Throughput: special case 1 op per 2 cycles; normal case 1 op per CORE_CYCLES+3 cycles with out_ready held high.
- Special-case table (s = sign N xor sign D):
  - Any sNaN input → 7FC00000, NV=1.
  - Any qNaN input (no sNaN) → 7FC00000, flags 00.
  - 0/0 or inf/inf → 7FC00000, NV=1.
  - Finite nonzero / 0 → {s,FF,0} (inf), DZ=1.
  - inf / finite → {s,FF,0}, flags 00.
  - Finite / inf, or 0 / finite nonzero → {s,00,0} (zero), flags 00.
- core_start is never asserted for special cases.
- Reset mid-operation (any state): operation abandoned, no out_valid pulse, core operands cleared. in_ready=1 on the first cycle after reset deasserts.
- in_valid without in_ready: no state change; operands are not sampled.
- Result rounding, overflow and underflow are the core's responsibility; this block passes core_quotient through unmodified.

Test Plan:
1. Normal op: request 3F800000/40000000 accepted at T; core model returns 3F000000.
   → core_start high only at T+1; out_valid at T+14 with result 3F000000, flags 00.
2. Specials, each accepted at T, result at T+1, core_start stays 0:
   - 3F800000/00000000 → 7F800000 DZ=1.
   - 80000000/00000000 → 7FC00000 NV=1.
   - 7F800001/3F800000 → 7FC00000 NV=1.
   - 7FC00001/3F800000 → 7FC00000 flags 00.
   - BF800000/7F800000 → 80000000.
3. Backpressure: hold out_ready=0 for 20 cycles after out_valid.
   → out_valid and out_result held constant, in_ready=0 throughout. Raise out_ready → out_valid drops next cycle, in_ready=1.
4. Reset mid-BUSY: assert reset for 1 cycle 5 cycles after core_start.
   → out_valid never rises; in_ready=1 on the cycle after reset falls; core_dividend=0.
5. Back-to-back: in_valid held high with two normal ops, out_ready=1.
   → second accept occurs in the IDLE cycle right after the first output handshake; two results in order, each CORE_CYCLES+2 cycles after its accept.
6. Subnormal flush: 00400000/3F800000 → 00000000 flags 00 at T+1; 3F800000/80400000 → FF800000 DZ=1.
